// File: rtl/am_error_stats.sv
// ---------------------------------------------------------------------------
// am_error_stats
//
// Streaming error-statistics collector for unsigned WIDTH x WIDTH approximate
// multipliers. Each accepted sample (x, y, z) is compared against the exact
// product x*y. Over a window of 2^WIN_LOG2 samples the block accumulates the
// sum of |z - x*y|, the largest |z - x*y| and the count of inexact samples.
// One record per window is then offered on a valid/ready handshake.
//
// Optional feature (macro AM_ERR_BIAS_EN):
//   defined   - a signed accumulator of (z - x*y) is kept and reported on
//               err_bias with the same timing as err_sum.
//   undefined - no bias accumulator; err_bias is tied to 0.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst       - asynchronous active-high reset
//   in_valid  - sample present on x/y/z
//   in_ready  - block accepts a sample this cycle (only in ACCUM)
//   x, y      - operands as fed to the multiplier under test
//   z         - approximate product returned by the multiplier
//   clear     - synchronous abort of the window in progress (ignored in REPORT)
//   out_valid - result record valid
//   out_ready - consumer accepts the record
//   err_sum   - sum of |z - x*y| over the window
//   err_max   - largest |z - x*y| in the window
//   err_cnt   - number of samples with z != x*y
//   err_bias  - signed sum of (z - x*y), two's complement
// ---------------------------------------------------------------------------
module am_error_stats #(
  parameter int WIDTH    = 8,
  parameter int WIN_LOG2 = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            x,
  input  logic [WIDTH-1:0]            y,
  input  logic [2*WIDTH-1:0]          z,
  input  logic                        clear,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*WIDTH+WIN_LOG2-1:0] err_sum,
  output logic [2*WIDTH-1:0]          err_max,
  output logic [WIN_LOG2:0]           err_cnt,
  output logic [2*WIDTH+WIN_LOG2:0]   err_bias
);

  localparam int PW = 2 * WIDTH;        // product / magnitude width
  localparam int SW = PW + WIN_LOG2;    // unsigned sum width
  localparam int NW = WIN_LOG2 + 1;     // sample counter width

  // acc_n value just before the window-closing accept
  localparam logic [NW-1:0] WIN_LAST = {1'b0, {WIN_LOG2{1'b1}}};

  typedef enum logic [1:0] {
    S_ACCUM  = 2'd0,
    S_DRAIN  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_in_ready;
  logic            r_out_valid;

  // pipeline stage 1: exact product and approximate product
  logic            r_s1_valid;
  logic [PW-1:0]   r_s1_prod;
  logic [PW-1:0]   r_s1_z;

  // pipeline stage 2: signed difference and its magnitude
  logic            r_s2_valid;
  logic [PW:0]     r_s2_diff;
  logic [PW-1:0]   r_s2_abs;

  // window accumulators
  logic [SW-1:0]   r_acc_sum;
  logic [PW-1:0]   r_acc_max;
  logic [NW-1:0]   r_acc_cnt;
  logic [NW-1:0]   r_acc_n;

  // reported record
  logic [SW-1:0]   r_err_sum;
  logic [PW-1:0]   r_err_max;
  logic [NW-1:0]   r_err_cnt;

  logic            w_accept;
  logic            w_flush;
  logic            w_load;
  logic [PW-1:0]   w_prod;
  logic [PW:0]     w_s1_diff;
  logic [PW-1:0]   w_s1_abs;

  // in_ready is only ever high in ACCUM, so an accept implies ACCUM
  assign w_accept = in_valid & r_in_ready;

  // clear aborts ACCUM/DRAIN; a consumed record also empties the window state
  assign w_flush  = (clear & (r_state != S_REPORT)) |
                    ((r_state == S_REPORT) & out_ready);

  // last sample has left the pipeline and is already in the accumulators
  assign w_load   = (r_state == S_DRAIN) & ~clear & ~r_s1_valid & ~r_s2_valid;

  assign w_prod    = PW'(x) * PW'(y);
  assign w_s1_diff = {1'b0, r_s1_z} - {1'b0, r_s1_prod};
  // magnitude computed from the side that cannot underflow
  assign w_s1_abs  = w_s1_diff[PW] ? (r_s1_prod - r_s1_z) : (r_s1_z - r_s1_prod);

  // datapath: pipeline, accumulators and sample counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_prod  <= '0;
      r_s1_z     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_diff  <= '0;
      r_s2_abs   <= '0;
      r_acc_sum  <= '0;
      r_acc_max  <= '0;
      r_acc_cnt  <= '0;
      r_acc_n    <= '0;
    end else if (w_flush) begin
      // an accept coinciding with clear is dropped here as well
      r_s1_valid <= 1'b0;
      r_s1_prod  <= '0;
      r_s1_z     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_diff  <= '0;
      r_s2_abs   <= '0;
      r_acc_sum  <= '0;
      r_acc_max  <= '0;
      r_acc_cnt  <= '0;
      r_acc_n    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_prod <= w_prod;
        r_s1_z    <= z;
        r_acc_n   <= r_acc_n + NW'(1);
      end

      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_diff <= w_s1_diff;
        r_s2_abs  <= w_s1_abs;
      end

      if (r_s2_valid) begin
        r_acc_sum <= r_acc_sum + SW'(r_s2_abs);
        if (r_s2_abs > r_acc_max) begin
          r_acc_max <= r_s2_abs;
        end
        r_acc_cnt <= r_acc_cnt + NW'(r_s2_diff != '0);
      end
    end
  end

  // control FSM with registered handshake outputs and result record
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_ACCUM;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_err_sum   <= '0;
      r_err_max   <= '0;
      r_err_cnt   <= '0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          r_in_ready <= 1'b1;
          if (!clear && w_accept && (r_acc_n == WIN_LAST)) begin
            r_state    <= S_DRAIN;
            r_in_ready <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (clear) begin
            r_state    <= S_ACCUM;
            r_in_ready <= 1'b1;
          end else if (w_load) begin
            r_err_sum   <= r_acc_sum;
            r_err_max   <= r_acc_max;
            r_err_cnt   <= r_acc_cnt;
            r_out_valid <= 1'b1;
            r_state     <= S_REPORT;
          end
        end
        S_REPORT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_ACCUM;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_ACCUM;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef AM_ERR_BIAS_EN
  logic [SW:0] r_acc_bias;
  logic [SW:0] r_err_bias;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_bias <= '0;
      r_err_bias <= '0;
    end else begin
      if (w_flush) begin
        r_acc_bias <= '0;
      end else if (r_s2_valid) begin
        // sign-extend the (PW+1)-bit difference to the accumulator width
        r_acc_bias <= r_acc_bias + {{WIN_LOG2{r_s2_diff[PW]}}, r_s2_diff};
      end
      if (w_load) begin
        r_err_bias <= r_acc_bias;
      end
    end
  end

  assign err_bias = r_err_bias;
`else
  assign err_bias = '0;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign err_sum   = r_err_sum;
  assign err_max   = r_err_max;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_am_error_stats.sv
// ---------------------------------------------------------------------------
// tb_am_error_stats
//
// Bench for am_error_stats with WIDTH=8, WIN_LOG2=2 (4-sample windows).
// Expected records are computed from the list of samples the bench itself
// delivered, using plain integer arithmetic on the error definitions.
// ---------------------------------------------------------------------------
module tb_am_error_stats;

  localparam int WIDTH    = 8;
  localparam int WIN_LOG2 = 2;
  localparam int BW       = 2 * WIDTH + WIN_LOG2 + 1;
  localparam logic [63:0] BMASK = (64'd1 << BW) - 64'd1;

  logic                        clk;
  logic                        rst;
  logic                        in_valid;
  logic                        in_ready;
  logic [WIDTH-1:0]            x;
  logic [WIDTH-1:0]            y;
  logic [2*WIDTH-1:0]          z;
  logic                        clear;
  logic                        out_valid;
  logic                        out_ready;
  logic [2*WIDTH+WIN_LOG2-1:0] err_sum;
  logic [2*WIDTH-1:0]          err_max;
  logic [WIN_LOG2:0]           err_cnt;
  logic [2*WIDTH+WIN_LOG2:0]   err_bias;

  am_error_stats #(
    .WIDTH    (WIDTH),
    .WIN_LOG2 (WIN_LOG2)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .z         (z),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_sum   (err_sum),
    .err_max   (err_max),
    .err_cnt   (err_cnt),
    .err_bias  (err_bias)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int win_id = 0;

  logic [7:0]  q_x[$];
  logic [7:0]  q_y[$];
  logic [15:0] q_z[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference: statistics of the samples delivered in this window
  task automatic model(output longint s, output longint m, output longint c, output longint b);
    longint d;
    longint a;
    s = 0; m = 0; c = 0; b = 0;
    foreach (q_x[i]) begin
      d = longint'(q_z[i]) - longint'(q_x[i]) * longint'(q_y[i]);
      a = (d < 0) ? -d : d;
      s += a;
      if (a > m) m = a;
      if (d != 0) c++;
      b += d;
    end
  endtask

  task automatic rand_sample(output logic [7:0] sx, output logic [7:0] sy, output logic [15:0] sz);
    int p;
    int zz;
    sx = 8'($urandom);
    sy = 8'($urandom);
    p  = int'(sx) * int'(sy);
    case ($urandom_range(0, 3))
      0: zz = p;
      1: zz = p + int'($urandom_range(0, 20)) - 10;
      2: zz = int'($urandom_range(0, 65535));
      default: zz = ($urandom_range(0, 1) == 1) ? 65535 : 0;
    endcase
    if (zz < 0) zz = 0;
    if (zz > 65535) zz = 65535;
    sz = 16'(zz);
  endtask

  // idle for gap cycles, then present one sample for one cycle
  task automatic send_sample(input logic [7:0] sx, input logic [7:0] sy, input logic [15:0] sz,
                             input int gap);
    in_valid = 1'b0;
    repeat (gap) tick();
    check_val("in_ready_accum", 64'(in_ready), 64'd1);
    x = sx; y = sy; z = sz;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    q_x.push_back(sx);
    q_y.push_back(sy);
    q_z.push_back(sz);
  endtask

  task automatic send_rand(input int n, input int gap_max);
    logic [7:0]  sx;
    logic [7:0]  sy;
    logic [15:0] sz;
    for (int i = 0; i < n; i++) begin
      rand_sample(sx, sy, sz);
      send_sample(sx, sy, sz, int'($urandom_range(0, gap_max)));
    end
  endtask

  // called one cycle after the final accept of a window
  task automatic close_window(input int hold, input bit pulse_clear);
    longint es, em, ec, eb;
    logic [63:0] eb_chk;
    int lat;
    model(es, em, ec, eb);
`ifdef AM_ERR_BIAS_EN
    eb_chk = 64'(eb) & BMASK;
`else
    eb_chk = 64'd0;
`endif
    check_val("in_ready_drop", 64'(in_ready), 64'd0);
    // in_valid pulses while the block is not ready must be ignored
    in_valid = 1'b1;
    x = 8'($urandom); y = 8'($urandom); z = 16'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check_val("latency", 64'(lat), 64'd3);
    for (int i = 0; i <= hold; i++) begin
      check_val("out_valid_hi", 64'(out_valid), 64'd1);
      check_val("in_ready_report", 64'(in_ready), 64'd0);
      check_val("err_sum", 64'(err_sum), 64'(es));
      check_val("err_max", 64'(err_max), 64'(em));
      check_val("err_cnt", 64'(err_cnt), 64'(ec));
      check_val("err_bias", 64'(err_bias), eb_chk);
      in_valid = 1'($urandom_range(0, 1));
      clear    = pulse_clear & 1'($urandom_range(0, 1));
      x = 8'($urandom); y = 8'($urandom); z = 16'($urandom);
      if (i < hold) tick();
    end
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("out_valid_lo", 64'(out_valid), 64'd0);
    check_val("in_ready_back", 64'(in_ready), 64'd1);
    $display("window %0d: sum=%0d max=%0d cnt=%0d bias=%0d lat=%0d hold=%0d",
             win_id, es, em, ec, eb, lat, hold);
    win_id++;
    q_x.delete(); q_y.delete(); q_z.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; z = '0;
    clear = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", 64'(in_ready), 64'd0);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_err_sum", 64'(err_sum), 64'd0);
    check_val("rst_err_max", 64'(err_max), 64'd0);
    check_val("rst_err_cnt", 64'(err_cnt), 64'd0);
    check_val("rst_err_bias", 64'(err_bias), 64'd0);
    rst = 1'b0;
    tick();
    check_val("in_ready_after_rst", 64'(in_ready), 64'd1);

    // exact products
    send_sample(8'd3, 8'd5, 16'd15, 0);
    send_sample(8'd255, 8'd255, 16'd65025, 0);
    send_sample(8'd0, 8'd7, 16'd0, 0);
    send_sample(8'd128, 8'd2, 16'd256, 0);
    close_window(0, 1'b0);

    // errors -1, +4, 0, -65025
    send_sample(8'd3, 8'd5, 16'd14, 0);
    send_sample(8'd2, 8'd2, 16'd8, 0);
    send_sample(8'd1, 8'd1, 16'd1, 0);
    send_sample(8'd255, 8'd255, 16'd0, 0);
    close_window(0, 1'b0);

    // backpressure for 10 cycles with clear pulses in REPORT, then a fresh window
    send_rand(4, 0);
    close_window(10, 1'b1);
    send_rand(4, 0);
    close_window(0, 1'b0);

    // sparse input: same error pattern, one idle cycle between samples
    send_sample(8'd3, 8'd5, 16'd14, 1);
    send_sample(8'd2, 8'd2, 16'd8, 1);
    send_sample(8'd1, 8'd1, 16'd1, 1);
    send_sample(8'd255, 8'd255, 16'd0, 1);
    close_window(0, 1'b0);

    // clear after 2 accepts, with an accept coinciding with the clear
    send_rand(2, 0);
    x = 8'd255; y = 8'd255; z = 16'd0;
    in_valid = 1'b1;
    clear = 1'b1;
    tick();
    in_valid = 1'b0;
    clear = 1'b0;
    check_val("in_ready_after_clear", 64'(in_ready), 64'd1);
    q_x.delete(); q_y.delete(); q_z.delete();
    send_rand(4, 0);
    close_window(0, 1'b0);

    // reset pulse while draining
    send_sample(8'd255, 8'd255, 16'd0, 0);
    send_sample(8'd200, 8'd100, 16'd3, 0);
    send_sample(8'd9, 8'd9, 16'd80, 0);
    send_sample(8'd17, 8'd4, 16'd60, 0);
    rst = 1'b1;
    #1;
    check_val("drain_rst_out_valid", 64'(out_valid), 64'd0);
    check_val("drain_rst_in_ready", 64'(in_ready), 64'd0);
    check_val("drain_rst_err_sum", 64'(err_sum), 64'd0);
    check_val("drain_rst_err_max", 64'(err_max), 64'd0);
    check_val("drain_rst_err_cnt", 64'(err_cnt), 64'd0);
    check_val("drain_rst_err_bias", 64'(err_bias), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check_val("in_ready_after_drain_rst", 64'(in_ready), 64'd1);
    q_x.delete(); q_y.delete(); q_z.delete();
    send_rand(4, 0);
    close_window(0, 1'b0);

    // randomized windows
    for (int w = 0; w < 25; w++) begin
      send_rand(4, 2);
      close_window(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/am_error_stats.md
Name: am_error_stats

Overview:
- Streaming error-statistics collector placed directly downstream of the unsigned 8x8 approximate multipliers.
- Takes each operand pair (x, y) and the approximate product z from the multiplier under test, and computes the exact product internally.
- Accumulates error statistics over a window of 2^WIN_LOG2 samples, then presents one result record per window through a valid/ready handshake.
- Used for on-chip characterisation of approximate multiplier variants.

Parameters:
- WIDTH, 8, operand width; products and errors are 2*WIDTH bits wide.
- WIN_LOG2, 8, log2 of the number of samples per window.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  sample present on x/y/z.
- in_ready  output  1  block accepts a sample this cycle.
- x  input  WIDTH  operand x as fed to the multiplier.
- y  input  WIDTH  operand y.
- z  input  2*WIDTH  approximate product returned by the multiplier.
- clear  input  1  synchronous abort: discards the window in progress.
- out_valid  output  1  result record is valid.
- out_ready  input  1  consumer accepts the record.
- err_sum  output  2*WIDTH+WIN_LOG2  sum of |z - x*y| over the window.
- err_max  output  2*WIDTH  largest |z - x*y| in the window.
- err_cnt  output  WIN_LOG2+1  number of samples with z != x*y.
- err_bias  output  2*WIDTH+WIN_LOG2+1  signed sum of (z - x*y); see Optional Feature.

Behaviour:
- Reset values: in_ready=0 while rst is high, and 1 in the first cycle after rst is released. out_valid=0. err_sum, err_max, err_cnt and err_bias are 0. State is ACCUM, and all counters and accumulators are 0.
- Accept rule: a sample is accepted when in_valid & in_ready. in_ready is 1 only in ACCUM.
- Pipeline stage 1 registers the exact product x*y, z, and a valid bit.
- Pipeline stage 2 registers the signed difference d = z - x*y (2*WIDTH+1 bits) and |d|.
- Stage 3 accumulation then updates the window state:
  - sum += |d|
  - max = max(max, |d|)
  - cnt += (d != 0)
- Every operation is unsigned and zero-extended, with no saturation. Widths are sized so that no overflow can occur at full window.
- Sample counter acc_n (WIN_LOG2+1 bits) increments on each accept.
- State ACCUM:
  - When an accept makes acc_n == 2^WIN_LOG2, in_ready drops in the next cycle and the state moves to DRAIN.
- State DRAIN:
  - Waits until both pipeline valid bits are 0; the last sample is then accumulated. This takes exactly 2 cycles after the final accept.
  - Then the accumulators are copied to the output registers, out_valid=1, and the state moves to REPORT.
- State REPORT:
  - Outputs are held stable while out_valid & !out_ready.
  - On out_ready, out_valid drops in the next cycle; the accumulators, acc_n and pipeline are cleared, and the state returns to ACCUM with in_ready=1.
- End-to-end latency: from the final accept to out_valid=1 is 3 cycles.
- clear in ACCUM or DRAIN: flushes the pipeline, accumulators and acc_n in the next cycle, and the state becomes ACCUM. Samples in flight are discarded. If an accept coincides with clear, that sample is also discarded.
- clear in REPORT: ignored. The record must be consumed first.
- in_valid while in_ready=0: ignored, no side effect.
- Reset mid-window or mid-REPORT: returns immediately to the reset values, and the partial window is lost.
- The block is a pure observer; it never modifies x, y or z.

Optional Feature:
- AM_ERR_BIAS_EN defined:
  - An additional signed accumulator of d (2*WIDTH+WIN_LOG2+1 bits, two's complement) is kept.
  - It is reported on err_bias with the same timing, clear and reset rules as err_sum.
- AM_ERR_BIAS_EN undefined:
  - The accumulator is not instantiated, and err_bias is tied to 0.

Test Plan:
- WIN_LOG2=2, four samples with z exact (3*5=15, 255*255=65025, 0*7=0, 128*2=256) -> after 3 cycles: out_valid=1, err_sum=0, err_max=0, err_cnt=0.
- WIN_LOG2=2, errors of -1, +4, 0 and -65025 (the last is x=y=255 with z=0) -> err_sum=65030, err_max=65025, err_cnt=3. With AM_ERR_BIAS_EN, err_bias=-65022.
- Backpressure: hold out_ready=0 for 10 cycles in REPORT -> outputs stable, in_ready=0, in_valid pulses ignored. Release -> the next window starts from zero.
- Sparse input: in_valid toggles every other cycle -> totals identical to the back-to-back case, and the window closes only after the 4th accept.
- clear asserted after 2 accepts -> the next 4 accepts form a clean window. Totals reflect only those 4 samples.
- rst asserted for 1 cycle in DRAIN -> out_valid=0 and all outputs 0 immediately. in_ready=1 one cycle after release, and a full new window is reported correctly.
